// File: rtl/urv_mem_writeback_if.sv
// ============================================================================
// Module   : urv_mem_writeback_if
// Purpose  : Signal bundle between the X/W pipeline registers, the data
//            memory response path, the register file write port and the
//            execute-stage bypass, as seen by the uRV writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface urv_mem_writeback_if;
  // W-stage instruction (from the X/W pipeline registers)
  logic        w_valid_i;
  logic        w_load_i;
  logic        w_store_i;
  logic [2:0]  w_fun_i;
  logic [31:0] w_dm_addr_i;
  logic [4:0]  w_rd_i;
  logic        w_rd_write_i;
  logic [1:0]  w_rd_source_i;
  logic [31:0] w_rd_value_i;
  logic [31:0] w_rd_shifter_i;
  logic [31:0] w_rd_multiply_i;
  logic [1:0]  w_ecc_flip_i;
  // Data memory response
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic        dm_store_done_i;
  // Pipeline control
  logic        w_stall_req_o;
  logic        w_bus_err_o;
  // Register file write port
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_write_o;
  logic [1:0]  rf_ecc_flip_o;
  // Bypass back to execute
  logic [4:0]  x_byp_rd_o;
  logic [31:0] x_byp_value_o;
  logic        x_byp_write_o;

  // Upstream / environment side
  modport master (
    output w_valid_i, w_load_i, w_store_i, w_fun_i, w_dm_addr_i, w_rd_i,
           w_rd_write_i, w_rd_source_i, w_rd_value_i, w_rd_shifter_i,
           w_rd_multiply_i, w_ecc_flip_i, dm_data_l_i, dm_load_done_i,
           dm_store_done_i,
    input  w_stall_req_o, w_bus_err_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o,
           rf_ecc_flip_o, x_byp_rd_o, x_byp_value_o, x_byp_write_o
  );

  // Writeback stage side
  modport slave (
    input  w_valid_i, w_load_i, w_store_i, w_fun_i, w_dm_addr_i, w_rd_i,
           w_rd_write_i, w_rd_source_i, w_rd_value_i, w_rd_shifter_i,
           w_rd_multiply_i, w_ecc_flip_i, dm_data_l_i, dm_load_done_i,
           dm_store_done_i,
    output w_stall_req_o, w_bus_err_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o,
           rf_ecc_flip_o, x_byp_rd_o, x_byp_value_o, x_byp_write_o
  );
endinterface

`default_nettype wire

// File: rtl/urv_mem_writeback.sv
// ============================================================================
// Module   : urv_mem_writeback
// Purpose  : uRV writeback stage. Waits for data-memory completion (stalling
//            the pipeline meanwhile), aligns/extends load data, selects the
//            result source, drives the register-file write port and keeps a
//            one-cycle bypass copy of the last write for execute.
// Options  : URV_WB_TIMEOUT_EN - abort a memory wait after g_timeout_cycles
//            WAIT_MEM cycles and pulse w_bus_err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module urv_mem_writeback #(
  parameter int g_timeout_cycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  urv_mem_writeback_if.slave   wb
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_t;

  state_t      state_q, state_d;

  logic        mem_busy;
  logic        mem_done;
  logic        timeout_hit;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_value;
  logic [31:0] alu_value;
  logic [31:0] rf_value;
  logic        rf_write;
  logic [1:0]  rf_ecc;

  logic [4:0]  x_byp_rd_q, x_byp_rd_d;
  logic [31:0] x_byp_value_q, x_byp_value_d;
  logic        x_byp_write_q, x_byp_write_d;

  // Address bits above the byte lane never influence the result.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^wb.w_dm_addr_i[31:2];

  // Memory handshake status; a load takes priority over a store.
  always_comb begin
    mem_busy = wb.w_valid_i & (wb.w_load_i | wb.w_store_i);
    mem_done = wb.w_load_i ? wb.dm_load_done_i : wb.dm_store_done_i;
  end

  // Next FSM state: wait for the matching done, leave on done or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_busy && !mem_done) begin
          state_d = ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: begin
        if (!mem_busy || mem_done || timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef URV_WB_TIMEOUT_EN
  localparam logic [7:0] c_timeout_last = 8'(g_timeout_cycles - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       bus_err_q, bus_err_d;

  // Count consecutive WAIT_MEM cycles; a done in the timeout cycle wins.
  always_comb begin
    timeout_hit = (state_q == ST_WAIT_MEM) && mem_busy && !mem_done &&
                  (wait_cnt_q == c_timeout_last);
    wait_cnt_d  = 8'd0;
    if ((state_q == ST_WAIT_MEM) && (state_d == ST_WAIT_MEM)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    bus_err_d   = timeout_hit;
  end

  // Wait counter and one-cycle bus-error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= 8'd0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign wb.w_bus_err_o = bus_err_q;
`else
  // Without the timeout a wait lasts until the memory answers.
  assign timeout_hit    = 1'b0;
  assign wb.w_bus_err_o = 1'b0;
`endif

  // Load lane selection and sign/zero extension.
  always_comb begin
    lane_byte = wb.dm_data_l_i[8*wb.w_dm_addr_i[1:0] +: 8];
    lane_half = wb.w_dm_addr_i[1] ? wb.dm_data_l_i[31:16] : wb.dm_data_l_i[15:0];
    case (wb.w_fun_i)
      3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_value = {24'd0, lane_byte};
      3'b101:  load_value = {16'd0, lane_half};
      default: load_value = wb.dm_data_l_i;
    endcase
  end

  // Result source selection and register-file write qualification.
  always_comb begin
    case (wb.w_rd_source_i)
      2'd1:    alu_value = wb.w_rd_shifter_i;
      2'd2:    alu_value = wb.w_rd_multiply_i;
      default: alu_value = wb.w_rd_value_i;
    endcase
    rf_value = wb.w_load_i ? load_value : alu_value;
    // Stores never write; a timed-out load never sees its done.
    rf_write = !rst_i && wb.w_valid_i && wb.w_rd_write_i && (wb.w_rd_i != 5'd0) &&
               (!wb.w_load_i || wb.dm_load_done_i) &&
               !(wb.w_store_i && !wb.w_load_i) && !timeout_hit;
    rf_ecc   = rf_write ? wb.w_ecc_flip_i : 2'b00;
  end

  // Next values of the execute bypass registers: a copy of this cycle's write.
  always_comb begin
    x_byp_rd_d    = wb.w_rd_i;
    x_byp_value_d = rf_value;
    x_byp_write_d = rf_write;
  end

  // FSM state and bypass registers; the bypass keeps updating during stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      x_byp_rd_q    <= 5'd0;
      x_byp_value_q <= 32'd0;
      x_byp_write_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_byp_rd_q    <= x_byp_rd_d;
      x_byp_value_q <= x_byp_value_d;
      x_byp_write_q <= x_byp_write_d;
    end
  end

  // Stall is combinational so a done in the first cycle costs nothing.
  assign wb.w_stall_req_o = !rst_i && mem_busy && !mem_done && !timeout_hit;

  assign wb.rf_rd_o       = wb.w_rd_i;
  assign wb.rf_rd_value_o = rf_value;
  assign wb.rf_rd_write_o = rf_write;
  assign wb.rf_ecc_flip_o = rf_ecc;

  assign wb.x_byp_rd_o    = x_byp_rd_q;
  assign wb.x_byp_value_o = x_byp_value_q;
  assign wb.x_byp_write_o = x_byp_write_q;

  // Execute never issues a load and a store together.
  a_no_load_and_store: assert property (@(posedge clk_i) disable iff (rst_i)
    !(wb.w_valid_i && wb.w_load_i && wb.w_store_i));

  // Timeout length must fit the 8-bit wait counter.
  a_timeout_range: assert property (@(posedge clk_i)
    (g_timeout_cycles >= 1) && (g_timeout_cycles <= 255));

endmodule

`default_nettype wire

// File: tb/tb_urv_mem_writeback.sv
// ============================================================================
// Module   : tb_urv_mem_writeback
// Purpose  : Directed self-checking bench for urv_mem_writeback with an
//            expected-write scoreboard. Build with URV_WB_TIMEOUT_EN defined
//            to exercise the timeout path (timeout = 4 cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_urv_mem_writeback;

`ifdef URV_WB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 16;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [1:0]  ecc;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  wr_t  exp_q[$];

  urv_mem_writeback_if bus ();

  urv_mem_writeback #(.g_timeout_cycles(TB_TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RF write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.rf_rd_write_o === 1'b1) begin
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_rd", 32'(bus.rf_rd_o), 32'(e.rd));
        check("wr_value", bus.rf_rd_value_o, e.val);
        check("wr_ecc", 32'(bus.rf_ecc_flip_o), 32'(e.ecc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.w_valid_i       = 1'b0;
    bus.w_load_i        = 1'b0;
    bus.w_store_i       = 1'b0;
    bus.w_fun_i         = 3'b000;
    bus.w_dm_addr_i     = 32'd0;
    bus.w_rd_i          = 5'd0;
    bus.w_rd_write_i    = 1'b0;
    bus.w_rd_source_i   = 2'd0;
    bus.w_rd_value_i    = 32'd0;
    bus.w_rd_shifter_i  = 32'd0;
    bus.w_rd_multiply_i = 32'd0;
    bus.w_ecc_flip_i    = 2'b00;
    bus.dm_data_l_i     = 32'd0;
    bus.dm_load_done_i  = 1'b0;
    bus.dm_store_done_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load or store completing after 'delay' stall cycles.
  task automatic mem_op(input string tag, input logic is_load, input logic [2:0] fun,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input int delay, input logic [31:0] exp_val);
    logic exp_wr;
    exp_wr = is_load && (rd != 5'd0);
    bus.w_valid_i       = 1'b1;
    bus.w_load_i        = is_load;
    bus.w_store_i       = !is_load;
    bus.w_fun_i         = fun;
    bus.w_dm_addr_i     = addr;
    bus.w_rd_i          = rd;
    bus.w_rd_write_i    = is_load;
    bus.w_rd_source_i   = 2'd0;
    bus.w_rd_value_i    = 32'h5A5A_5A5A;
    bus.w_rd_shifter_i  = 32'h1111_1111;
    bus.w_rd_multiply_i = 32'h2222_2222;
    bus.w_ecc_flip_i    = 2'b10;
    if (exp_wr) exp_q.push_back('{rd: rd, val: exp_val, ecc: 2'b10});
    for (int c = 0; c <= delay; c++) begin
      if (c == delay) begin
        if (is_load) begin
          bus.dm_load_done_i = 1'b1;
          bus.dm_data_l_i    = data;
        end else begin
          bus.dm_store_done_i = 1'b1;
        end
      end
      @(negedge clk);
      check({tag, "_stall"}, 32'(bus.w_stall_req_o), 32'(c < delay));
      check({tag, "_buserr"}, 32'(bus.w_bus_err_o), 32'd0);
      step();
      bus.dm_load_done_i  = 1'b0;
      bus.dm_store_done_i = 1'b0;
      bus.dm_data_l_i     = 32'd0;
    end
    idle_inputs();
    @(negedge clk);
    check({tag, "_byp_write"}, 32'(bus.x_byp_write_o), 32'(exp_wr));
    if (exp_wr) begin
      check({tag, "_byp_rd"}, 32'(bus.x_byp_rd_o), 32'(rd));
      check({tag, "_byp_value"}, bus.x_byp_value_o, exp_val);
    end
    check({tag, "_buserr_after"}, 32'(bus.w_bus_err_o), 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    step();
  endtask

  // Single-cycle non-memory instruction.
  task automatic alu_op(input string tag, input logic [1:0] src, input logic [4:0] rd,
                        input logic rd_write, input logic [31:0] value,
                        input logic [31:0] shifter, input logic [31:0] multiply,
                        input logic [31:0] exp_val, input logic exp_wr);
    bus.w_valid_i       = 1'b1;
    bus.w_load_i        = 1'b0;
    bus.w_store_i       = 1'b0;
    bus.w_rd_i          = rd;
    bus.w_rd_write_i    = rd_write;
    bus.w_rd_source_i   = src;
    bus.w_rd_value_i    = value;
    bus.w_rd_shifter_i  = shifter;
    bus.w_rd_multiply_i = multiply;
    bus.w_ecc_flip_i    = 2'b01;
    if (exp_wr) exp_q.push_back('{rd: rd, val: exp_val, ecc: 2'b01});
    @(negedge clk);
    check({tag, "_stall"}, 32'(bus.w_stall_req_o), 32'd0);
    check({tag, "_rf_write"}, 32'(bus.rf_rd_write_o), 32'(exp_wr));
    check({tag, "_ecc"}, 32'(bus.rf_ecc_flip_o), exp_wr ? 32'd1 : 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check({tag, "_byp_write"}, 32'(bus.x_byp_write_o), 32'(exp_wr));
    if (exp_wr) begin
      check({tag, "_byp_rd"}, 32'(bus.x_byp_rd_o), 32'(rd));
      check({tag, "_byp_value"}, bus.x_byp_value_o, exp_val);
    end
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst = 1'b1;

    // Reset: outputs forced low even with a pending load presented.
    bus.w_valid_i    = 1'b1;
    bus.w_load_i     = 1'b1;
    bus.w_fun_i      = 3'b010;
    bus.w_rd_i       = 5'd4;
    bus.w_rd_write_i = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_stall", 32'(bus.w_stall_req_o), 32'd0);
    check("rst_rf_write", 32'(bus.rf_rd_write_o), 32'd0);
    check("rst_byp_write", 32'(bus.x_byp_write_o), 32'd0);
    check("rst_byp_rd", 32'(bus.x_byp_rd_o), 32'd0);
    check("rst_byp_value", bus.x_byp_value_o, 32'd0);
    check("rst_buserr", 32'(bus.w_bus_err_o), 32'd0);
    step();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(bus.w_stall_req_o), 32'd0);
    step();

    // Loads: lane selection and extension.
    mem_op("lb_a3",  1'b1, 3'b000, 32'h0000_1003, 32'h80FF_FF01, 5'd3,  2, 32'hFFFF_FF80);
    mem_op("lhu_a2", 1'b1, 3'b101, 32'h0000_2002, 32'hBEEF_1234, 5'd8,  0, 32'h0000_BEEF);
    mem_op("lh_a0",  1'b1, 3'b001, 32'h0000_2000, 32'h1234_8001, 5'd9,  1, 32'hFFFF_8001);
    mem_op("lbu_a1", 1'b1, 3'b100, 32'h0000_3001, 32'h1234_F0AB, 5'd10, 0, 32'h0000_00F0);
    mem_op("lb_a2",  1'b1, 3'b000, 32'h0000_3002, 32'h807F_00FF, 5'd12, 0, 32'h0000_007F);
    mem_op("lw_a0",  1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 5'd31, 1, 32'hCAFE_F00D);
    mem_op("lb_x0",  1'b1, 3'b000, 32'h0000_0000, 32'h0000_00AA, 5'd0,  1, 32'h0);

    // Store: stalls until accepted, never writes.
    mem_op("sw", 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd13, 3, 32'h0);

    // Non-memory results.
    alu_op("alu_x0",  2'd0, 5'd0, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b0);
    alu_op("shift",   2'd1, 5'd5, 1'b1, 32'hAAAA_AAAA, 32'h0000_0040, 32'h5555_5555, 32'h0000_0040, 1'b1);
    alu_op("mul",     2'd2, 5'd6, 1'b1, 32'hAAAA_AAAA, 32'h0000_0040, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1);
    alu_op("src0",    2'd0, 5'd7, 1'b1, 32'h7654_3210, 32'h1, 32'h2, 32'h7654_3210, 1'b1);
    alu_op("src3",    2'd3, 5'd2, 1'b1, 32'h0BAD_F00D, 32'h1, 32'h2, 32'h0BAD_F00D, 1'b1);
    alu_op("no_wr",   2'd0, 5'd7, 1'b0, 32'h1111_2222, 32'h1, 32'h2, 32'h0, 1'b0);

    // Invalid slot with load flags set: nothing happens.
    bus.w_valid_i    = 1'b0;
    bus.w_load_i     = 1'b1;
    bus.w_rd_i       = 5'd6;
    bus.w_rd_write_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("inv_stall", 32'(bus.w_stall_req_o), 32'd0);
      check("inv_rf_write", 32'(bus.rf_rd_write_o), 32'd0);
      step();
    end
    idle_inputs();
    mem_op("lw_after_inv", 1'b1, 3'b010, 32'h0, 32'h0000_1357, 5'd14, 0, 32'h0000_1357);

    // Reset in the middle of a load wait.
    bus.w_valid_i    = 1'b1;
    bus.w_load_i     = 1'b1;
    bus.w_fun_i      = 3'b010;
    bus.w_rd_i       = 5'd7;
    bus.w_rd_write_i = 1'b1;
    @(negedge clk);
    check("rstw_stall0", 32'(bus.w_stall_req_o), 32'd1);
    step();
    @(negedge clk);
    check("rstw_stall1", 32'(bus.w_stall_req_o), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rstw_stall_rst", 32'(bus.w_stall_req_o), 32'd0);
    check("rstw_write_rst", 32'(bus.rf_rd_write_o), 32'd0);
    step();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    check("rstw_byp_write", 32'(bus.x_byp_write_o), 32'd0);
    step();
    bus.dm_load_done_i = 1'b1;
    bus.dm_data_l_i    = 32'h1234_5678;
    @(negedge clk);
    check("rstw_late_done", 32'(bus.rf_rd_write_o), 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("rstw_late_byp", 32'(bus.x_byp_write_o), 32'd0);
    step();
    mem_op("lw_after_rst", 1'b1, 3'b010, 32'h0, 32'h2468_ACE0, 5'd15, 1, 32'h2468_ACE0);

`ifdef URV_WB_TIMEOUT_EN
    // Timeout with no done: stall released in the timeout cycle, error pulse next.
    bus.w_valid_i    = 1'b1;
    bus.w_load_i     = 1'b1;
    bus.w_fun_i      = 3'b010;
    bus.w_rd_i       = 5'd9;
    bus.w_rd_write_i = 1'b1;
    for (int c = 0; c < TB_TIMEOUT; c++) begin
      @(negedge clk);
      check("to_stall", 32'(bus.w_stall_req_o), 32'd1);
      check("to_buserr_wait", 32'(bus.w_bus_err_o), 32'd0);
      step();
    end
    @(negedge clk);
    check("to_release", 32'(bus.w_stall_req_o), 32'd0);
    check("to_no_write", 32'(bus.rf_rd_write_o), 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("to_buserr_pulse", 32'(bus.w_bus_err_o), 32'd1);
    check("to_byp_write", 32'(bus.x_byp_write_o), 32'd0);
    step();
    @(negedge clk);
    check("to_buserr_clear", 32'(bus.w_bus_err_o), 32'd0);
    step();
    // Done arriving in the timeout cycle completes normally.
    mem_op("to_done_last", 1'b1, 3'b010, 32'h0, 32'h0DDB_A11E, 5'd9, TB_TIMEOUT, 32'h0DDB_A11E);
`else
    // Long wait without a timeout: stall holds, no error is ever raised.
    mem_op("lw_long", 1'b1, 3'b010, 32'h0, 32'h0BAD_CAFE, 5'd11, 20, 32'h0BAD_CAFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
